// File: rtl/dram_cache_pkg.sv
// rtl/dram_cache_pkg.sv - shared types and address helpers for the DRAM cache lookup engine
package dram_cache_pkg;

    localparam int ADDR_W   = 64;
    localparam int ID_W     = 16;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int DATA_W   = 72;

    typedef struct packed {
        logic              write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } lookup_req_t;

    typedef struct packed {
        logic              hit;
        logic              write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } lookup_res_t;

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W+INDEX_W +: TAG_W];
    endfunction

endpackage

// File: rtl/dram_cache_lookup_engine_tracker.sv
// rtl/dram_cache_lookup_engine_tracker.sv - in-order circular buffer of outstanding lookups
module dram_cache_lookup_engine_tracker
    import dram_cache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  lookup_req_t              push_data,
    input  logic                     pop,
    output lookup_req_t              head,
    output logic [PTR_W:0]           count,
    output logic [DEPTH*INDEX_W-1:0] ent_index,
    output logic [DEPTH-1:0]         ent_write
);

    lookup_req_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ent_index = '0;
        ent_write = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_index[i*INDEX_W +: INDEX_W] = get_index(mem[i].addr);
            ent_write[i] = mem[i].write && ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

endmodule

// File: rtl/dram_cache_lookup_engine.sv
// rtl/dram_cache_lookup_engine.sv - in-order DRAM cache tag lookup engine with hazard stall and stats
module dram_cache_lookup_engine
    import dram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_W,
    parameter int ID_WIDTH        = ID_W,
    parameter int INDEX_WIDTH     = INDEX_W,
    parameter int OFFSET_WIDTH    = OFFSET_W,
    parameter int TAG_WIDTH       = TAG_W,
    parameter int DATA_WIDTH      = DATA_W,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    output logic [ID_WIDTH-1:0]    arid_o,
    output logic [INDEX_WIDTH-1:0] araddr_o,
    output logic                   arvalid_o,
    input  logic                   arready_i,
    input  logic [DATA_WIDTH-1:0]  rdata_i,
    input  logic [TAG_WIDTH:0]     rtag_i,
    input  logic                   rvalid_i,
    output logic                   rready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   res_hit_o,
    output logic                   res_write_o,
    output logic [ID_WIDTH-1:0]    res_id_o,
    output logic [ADDR_WIDTH-1:0]  res_addr_o,
    output logic [DATA_WIDTH-1:0]  res_data_o,
    output logic [CNT_WIDTH-1:0]   hit_cnt_o,
    output logic [CNT_WIDTH-1:0]   miss_cnt_o,
    output logic                   err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    logic [PTR_W:0]                         count;
    lookup_req_t                            push_data;
    lookup_req_t                            head;
    logic [MAX_OUTSTANDING-1:0]             ent_write;
    logic [MAX_OUTSTANDING*INDEX_WIDTH-1:0] ent_index;
    lookup_res_t                            res_q;
    logic [INDEX_WIDTH-1:0]                 req_index;
    logic                                   run;
    logic                                   hazard;
    logic                                   accept;
    logic                                   r_hs;
    logic                                   hit;

    dram_cache_lookup_engine_tracker #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_data),
        .pop       (r_hs),
        .head      (head),
        .count     (count),
        .ent_index (ent_index),
        .ent_write (ent_write)
    );

    assign req_index = req_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign push_data = '{write: req_write_i, id: req_id_i, addr: req_addr_i};

    // A write lookup owns its set until its result has left the result register.
    always_comb begin
        hazard = res_valid_o && res_q.write && (get_index(res_q.addr) == req_index);
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_write[i] && (ent_index[i*INDEX_WIDTH +: INDEX_WIDTH] == req_index)) hazard = 1'b1;
        end
    end

    // run keeps ready low while in reset; count MSB set means the tracker is full.
    assign req_ready_o = run && !count[PTR_W] && !hazard && (!arvalid_o || arready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign rready_o    = (count != '0) && (!res_valid_o || res_ready_i);
    assign r_hs        = rvalid_i && rready_o;
    assign hit         = rtag_i[TAG_WIDTH] &&
                         (rtag_i[TAG_WIDTH-1:0] == head.addr[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            arvalid_o <= 1'b0;
            arid_o    <= '0;
            araddr_o  <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                arvalid_o <= 1'b1;
                arid_o    <= req_id_i;
                araddr_o  <= req_index;
            end else if (arready_i) begin
                arvalid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_o <= 1'b0;
            res_q       <= '0;
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            if (rvalid_i && (count == '0)) err_o <= 1'b1;
            if (r_hs) begin
                res_valid_o <= 1'b1;
                res_q       <= '{hit: hit, write: head.write, id: head.id, addr: head.addr, data: rdata_i};
                if (hit) begin
                    if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
                end else begin
                    if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
                end
            end else if (res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end

    assign res_hit_o   = res_q.hit;
    assign res_write_o = res_q.write;
    assign res_id_o    = res_q.id;
    assign res_addr_o  = res_q.addr;
    assign res_data_o  = res_q.data;

endmodule

// File: tb/tb_dram_cache_lookup_engine.sv
// tb/tb_dram_cache_lookup_engine.sv - randomized and directed bench with queue-based reference model
module tb_dram_cache_lookup_engine;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic         req_write_i = 1'b0;
    logic [15:0]  req_id_i = '0;
    logic [63:0]  req_addr_i = '0;
    logic [15:0]  arid_o;
    logic [3:0]   araddr_o;
    logic         arvalid_o;
    logic         arready_i = 1'b0;
    logic [71:0]  rdata_i = '0;
    logic [55:0]  rtag_i = '0;
    logic         rvalid_i = 1'b0;
    logic         rready_o;
    logic         res_valid_o;
    logic         res_ready_i = 1'b0;
    logic         res_hit_o;
    logic         res_write_o;
    logic [15:0]  res_id_o;
    logic [63:0]  res_addr_o;
    logic [71:0]  res_data_o;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
    logic         err_o;

    always #5 clk = ~clk;

    dram_cache_lookup_engine dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (req_valid_i), .req_ready_o (req_ready_o), .req_write_i (req_write_i),
        .req_id_i (req_id_i), .req_addr_i (req_addr_i),
        .arid_o (arid_o), .araddr_o (araddr_o), .arvalid_o (arvalid_o), .arready_i (arready_i),
        .rdata_i (rdata_i), .rtag_i (rtag_i), .rvalid_i (rvalid_i), .rready_o (rready_o),
        .res_valid_o (res_valid_o), .res_ready_i (res_ready_i), .res_hit_o (res_hit_o),
        .res_write_o (res_write_o), .res_id_o (res_id_o), .res_addr_o (res_addr_o),
        .res_data_o (res_data_o), .hit_cnt_o (hit_cnt_o), .miss_cnt_o (miss_cnt_o), .err_o (err_o)
    );

    typedef struct {
        bit        w;
        bit [15:0] id;
        bit [63:0] addr;
    } req_s;

    req_s      trk[$];
    bit        run_m, ar_v, rs_v, rs_hit, rs_w, err_m;
    bit [15:0] ar_id, rs_id;
    bit [3:0]  ar_idx;
    bit [63:0] rs_addr;
    bit [71:0] rs_data;
    longint    hits, misses;
    bit        r_valid_bit, r_match, last_acc;
    int        errors = 0;
    int        checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [3:0] idx_of(input bit [63:0] a);
        return 4'((a / 32) % 16);
    endfunction

    function automatic bit [54:0] tag_of(input bit [63:0] a);
        return 55'(a / 512);
    endfunction

    function automatic bit [63:0] mk_addr(input int tag, input int idx, input int off);
        return 64'(tag) * 512 + 64'(idx) * 32 + 64'(off);
    endfunction

    function automatic bit blocked(input bit [63:0] a);
        bit b = rs_v && rs_w && (idx_of(rs_addr) == idx_of(a));
        foreach (trk[i]) if (trk[i].w && idx_of(trk[i].addr) == idx_of(a)) b = 1'b1;
        return b;
    endfunction

    task automatic model_clear();
        trk.delete();
        run_m = 0; ar_v = 0; rs_v = 0; err_m = 0; hits = 0; misses = 0;
    endtask

    // Called at posedge+1 with inputs set: checks pre-edge state, then advances the model one edge.
    task automatic step();
        bit   exp_ready, exp_rready, acc, rhs, hit;
        req_s h;
        if (trk.size() > 0)
            rtag_i = {r_valid_bit, r_match ? tag_of(trk[0].addr) : tag_of(trk[0].addr) ^ 55'h1};
        #1;
        exp_ready  = run_m && (trk.size() < N) && !blocked(req_addr_i) && (!ar_v || arready_i);
        exp_rready = (trk.size() != 0) && (!rs_v || res_ready_i);
        check("req_ready", req_ready_o, exp_ready);
        check("rready", rready_o, exp_rready);
        check("arvalid", arvalid_o, ar_v);
        if (ar_v) begin
            check("arid", arid_o, ar_id);
            check("araddr", araddr_o, ar_idx);
        end
        check("res_valid", res_valid_o, rs_v);
        if (rs_v) begin
            check("res_hit", res_hit_o, rs_hit);
            check("res_write", res_write_o, rs_w);
            check("res_id", res_id_o, rs_id);
            check("res_addr", res_addr_o, rs_addr);
            check("res_data", res_data_o, rs_data);
        end
        check("hit_cnt", hit_cnt_o, hits);
        check("miss_cnt", miss_cnt_o, misses);
        check("err", err_o, err_m);
        acc = req_valid_i && exp_ready;
        rhs = rvalid_i && exp_rready;
        last_acc = acc;
        if (rvalid_i && trk.size() == 0) err_m = 1;
        if (rhs) begin
            h = trk.pop_front();
            hit = rtag_i[55] && (rtag_i[54:0] == tag_of(h.addr));
            rs_v = 1; rs_hit = hit; rs_w = h.w; rs_id = h.id; rs_addr = h.addr; rs_data = rdata_i;
            if (hit) hits = (hits < 64'hFFFF_FFFF) ? hits + 1 : hits;
            else     misses = (misses < 64'hFFFF_FFFF) ? misses + 1 : misses;
        end else if (rs_v && res_ready_i) begin
            rs_v = 0;
        end
        if (acc) begin
            trk.push_back('{w: req_write_i, id: req_id_i, addr: req_addr_i});
            ar_v = 1; ar_id = req_id_i; ar_idx = idx_of(req_addr_i);
        end else if (ar_v && arready_i) begin
            ar_v = 0;
        end
        run_m = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit w, input bit [15:0] id, input bit [63:0] a);
        req_valid_i = 1; req_write_i = w; req_id_i = id; req_addr_i = a;
    endtask

    task automatic drain();
        req_valid_i = 0; res_ready_i = 1; arready_i = 1; r_valid_bit = 1;
        for (int k = 0; k < 40 && (trk.size() > 0 || rs_v || ar_v); k++) begin
            rvalid_i = (trk.size() > 0);
            r_match = 1'($urandom % 2);
            rdata_i = 72'({$urandom, $urandom, $urandom});
            step();
        end
        rvalid_i = 0;
        check("drain_bound", (trk.size() == 0 && !rs_v && !ar_v), 1'b1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctl"}, {req_ready_o, arvalid_o, rready_o, res_valid_o, res_hit_o, res_write_o, err_o}, 7'b0);
        check({tag, "_ar"}, {arid_o, araddr_o}, 20'b0);
        check({tag, "_res"}, {res_id_o, res_addr_o}, 80'b0);
        check({tag, "_data"}, res_data_o, 72'b0);
        check({tag, "_cnt"}, {hit_cnt_o, miss_cnt_o}, 64'b0);
    endtask

    initial begin
        model_clear();
        #2 rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        reset_check("reset");
        rst_n = 1;
        res_ready_i = 1; arready_i = 1; r_valid_bit = 1; r_match = 1;
        step();

        // single read, index 2, valid matching tag
        set_req(0, 16'h0011, 64'h1234_0040);
        step();
        req_valid_i = 0;
        check("t1_accept", last_acc, 1'b1);
        check("t1_araddr", {arvalid_o, araddr_o}, {1'b1, 4'd2});
        rvalid_i = 1; rdata_i = 72'hAB_CDEF_0123_4567_89AB;
        step();
        rvalid_i = 0;
        check("t1_hit", res_hit_o, 1'b1);
        check("t1_hit_cnt", hit_cnt_o, 32'd1);
        step();

        // invalid metadata with equal tag is a miss
        set_req(0, 16'h0022, 64'h1234_0060);
        step();
        req_valid_i = 0;
        rvalid_i = 1; r_valid_bit = 0; r_match = 1;
        step();
        rvalid_i = 0; r_valid_bit = 1;
        check("t2_hit", res_hit_o, 1'b0);
        check("t2_miss_cnt", miss_cnt_o, 32'd1);
        drain();

        // five back-to-back reads fill the tracker
        for (int k = 0; k < 5; k++) begin
            set_req(0, 16'(16'h100 + k), mk_addr(k + 7, k + 5, 0));
            step();
            check($sformatf("t3_accept%0d", k), last_acc, k < 4);
        end
        rvalid_i = 1; r_match = 1;
        step();
        rvalid_i = 0;
        check("t3_pop_cycle", last_acc, 1'b0);
        step();
        check("t3_after_pop", last_acc, 1'b1);
        drain();

        // write index 3 blocks a read of index 3 until its result leaves
        set_req(1, 16'h0301, mk_addr(9, 3, 4));
        step();
        check("t4_write_acc", last_acc, 1'b1);
        set_req(0, 16'h0302, mk_addr(5, 3, 0));
        step();
        check("t4_blocked", last_acc, 1'b0);
        set_req(0, 16'h0401, mk_addr(5, 4, 0));
        step();
        check("t4_other_idx", last_acc, 1'b1);
        req_valid_i = 0; res_ready_i = 0; rvalid_i = 1;
        step();
        rvalid_i = 0;
        set_req(0, 16'h0303, mk_addr(6, 3, 0));
        step();
        check("t4_res_block", last_acc, 1'b0);
        res_ready_i = 1;
        step();
        check("t4_res_leaving", last_acc, 1'b0);
        step();
        check("t4_released", last_acc, 1'b1);
        drain();

        // back-pressure on results with two R beats pending
        set_req(0, 16'h0501, mk_addr(1, 8, 0)); step();
        set_req(0, 16'h0502, mk_addr(2, 9, 0)); step();
        req_valid_i = 0; res_ready_i = 0; rvalid_i = 1;
        step();
        check("t5_rready_low", rready_o, 1'b0);
        step();
        check("t5_first_id", res_id_o, 16'h0501);
        res_ready_i = 1;
        step();
        rvalid_i = 0;
        check("t5_second_id", res_id_o, 16'h0502);
        drain();

        // R with empty tracker sets a sticky error
        rvalid_i = 1;
        step();
        rvalid_i = 0;
        check("t6_err_set", err_o, 1'b1);
        step(); step();
        check("t6_err_sticky", err_o, 1'b1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid_i = 1'($urandom % 2);
            req_write_i = 1'($urandom % 2);
            req_id_i    = 16'($urandom);
            req_addr_i  = mk_addr($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 31));
            arready_i   = 1'($urandom % 4 != 0);
            res_ready_i = 1'($urandom % 3 != 0);
            rvalid_i    = (trk.size() > 0) && ($urandom % 2 == 1);
            r_valid_bit = 1'($urandom % 4 != 0);
            r_match     = 1'($urandom % 2);
            rdata_i     = 72'({$urandom, $urandom, $urandom});
            step();
        end

        // reset in the middle of traffic discards everything
        res_ready_i = 0; rvalid_i = 0; arready_i = 1;
        set_req(0, 16'h0601, mk_addr(3, 10, 0)); step();
        set_req(0, 16'h0602, mk_addr(3, 11, 0)); step();
        req_valid_i = 0;
        rst_n = 0;
        #1;
        reset_check("mid_reset");
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
        res_ready_i = 1;
        for (int k = 0; k < 4; k++) step();
        check("no_stale_result", res_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
